// File: rtl/switch_pkg.sv
// Shared switch types and sizing helpers for the request arbiter and the
// switch allocator it feeds.
package switch_pkg;

    // Width of the saturating deny counter.
    localparam int DENY_W = 16;

    // What happened to the staged request in the current cycle.
    typedef enum logic [1:0] {
        STAGE_IDLE,      // nothing staged
        STAGE_GRANT,     // allocator accepted the request
        STAGE_DENY,      // allocator refused the request
        STAGE_WITHDRAW   // buffer dropped its request before it was served
    } stage_outcome_e;

    // Index width for N items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sa_request_arbiter_if.sv
// Buffer/allocator handshake bundle for the switch-allocation request arbiter.
// The slave side is the arbiter; the master side is the buffers plus the
// switch allocator.
interface sa_request_arbiter_if
    import switch_pkg::*;
#(
    parameter int NUM_BUFFERS  = 5,
    parameter int NUM_OUTPORTS = 5,
    parameter int NUM_VCS      = 2
);
    localparam int BUF_W = clog2_min1(NUM_BUFFERS);
    localparam int OP_W  = clog2_min1(NUM_OUTPORTS);
    localparam int VC_W  = clog2_min1(NUM_VCS);

    // Buffer side
    logic [NUM_BUFFERS-1:0]                 req_valid;
    logic [NUM_BUFFERS-1:0][OP_W-1:0]       req_outport;
    logic [NUM_BUFFERS-1:0][VC_W-1:0]       req_vc;
    logic [NUM_BUFFERS-1:0]                 req_grant;

    // Allocator side
    logic                                   allocate;
    logic [BUF_W-1:0]                       requestor;
    logic [OP_W-1:0]                        requested;
    logic [VC_W-1:0]                        requested_vc;
    logic                                   switch_valid;
    logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]   sa_enable;

    modport master (
        output req_valid, req_outport, req_vc, switch_valid, sa_enable,
        input  req_grant, allocate, requestor, requested, requested_vc
    );

    modport slave (
        input  req_valid, req_outport, req_vc, switch_valid, sa_enable,
        output req_grant, allocate, requestor, requested, requested_vc
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: returns the first set request at or
// after ptr, wrapping around, plus a found flag.
module rr_arbiter
    import switch_pkg::*;
#(
    parameter  int NUM_REQ = 5,
    localparam int PTR_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               found
);

    logic [PTR_W-1:0] idx;

    // Scan from ptr upward with wrap; the first hit wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise a latch is inferred.
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/sa_request_arbiter.sv
// Switch-allocation request arbiter: picks one buffer per cycle round-robin,
// holds it in a single stage register and presents it to the switch
// allocator. The stage is resolved (grant, deny or withdraw) every cycle it is
// occupied, so a fresh winner can be loaded behind every grant.
module sa_request_arbiter
    import switch_pkg::*;
#(
    parameter int NUM_BUFFERS  = 5,
    parameter int NUM_OUTPORTS = 5,
    parameter int NUM_VCS      = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    sa_request_arbiter_if.slave  bus,
    output logic [DENY_W-1:0]    deny_count
);

    localparam int BUF_W = clog2_min1(NUM_BUFFERS);
    localparam int OP_W  = clog2_min1(NUM_OUTPORTS);
    localparam int VC_W  = clog2_min1(NUM_VCS);

    // Stage and arbitration state
    logic             stage_valid;
    logic [BUF_W-1:0] stage_req;
    logic [OP_W-1:0]  stage_op;
    logic [VC_W-1:0]  stage_vc;
    logic [BUF_W-1:0] rr_ptr;

    logic [NUM_BUFFERS-1:0] cand;
    logic [BUF_W-1:0]       winner;
    logic                   found;
    logic                   grant_fire;
    stage_outcome_e         outcome;

    // An outport/VC pair already held by the allocator; out-of-range
    // coordinates can never be held.
    function automatic logic enable_hit(
        input logic [OP_W-1:0]                      op,
        input logic [VC_W-1:0]                      vc,
        input logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] map
    );
        if (int'(op) >= NUM_OUTPORTS || int'(vc) >= NUM_VCS)
            return 1'b0;
        return map[op][vc];
    endfunction

    assign bus.allocate     = stage_valid && bus.req_valid[stage_req];
    assign bus.requestor    = stage_req;
    assign bus.requested    = stage_op;
    assign bus.requested_vc = stage_vc;
    assign grant_fire       = bus.allocate && bus.switch_valid;

    // One-hot grant pulse to the staged buffer when the allocator accepts.
    always_comb begin
        bus.req_grant = '0;
        for (int i = 0; i < NUM_BUFFERS; i++)
            bus.req_grant[i] = grant_fire && (stage_req == BUF_W'(i));
    end

    // Classify what happens to the staged request this cycle.
    always_comb begin
        outcome = STAGE_IDLE;
        if (stage_valid) begin
            if (!bus.req_valid[stage_req])
                outcome = STAGE_WITHDRAW;
            else if (bus.switch_valid)
                outcome = STAGE_GRANT;
            else
                outcome = STAGE_DENY;
        end
    end

    // Candidates: valid, target not already allocated, and not colliding with
    // the request currently staged (same buffer or same outport/VC).
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            cand[i] = bus.req_valid[i]
                   && !enable_hit(bus.req_outport[i], bus.req_vc[i], bus.sa_enable)
                   && !(stage_valid
                        && ((stage_req == BUF_W'(i))
                            || (bus.req_outport[i] == stage_op
                                && bus.req_vc[i] == stage_vc)));
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_BUFFERS)
    ) u_rr_arbiter (
        .req    (cand),
        .ptr    (rr_ptr),
        .winner (winner),
        .found  (found)
    );

    // Reload the stage every cycle, advance the pointer past each winner and
    // count denials.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            stage_valid <= 1'b0;
            stage_req   <= '0;
            stage_op    <= '0;
            stage_vc    <= '0;
            rr_ptr      <= '0;
            deny_count  <= '0;
        end else begin
            stage_valid <= found;
            if (found) begin
                stage_req <= winner;
                stage_op  <= bus.req_outport[winner];
                stage_vc  <= bus.req_vc[winner];
                rr_ptr    <= (winner == BUF_W'(NUM_BUFFERS - 1)) ? '0 : winner + BUF_W'(1);
            end
            if (outcome == STAGE_DENY && deny_count != '1)
                deny_count <= deny_count + DENY_W'(1);
        end
    end

endmodule

// File: tb/tb_sa_request_arbiter.sv
// Directed bench for sa_request_arbiter: single request, fairness, conflict
// masking, deny counting, withdraw, pointer wrap and reset mid-operation.
module tb_sa_request_arbiter;

    localparam int NB = 5;
    localparam int NO = 5;
    localparam int NV = 2;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [15:0] deny_count;

    int checks = 0;
    int errors = 0;

    sa_request_arbiter_if #(
        .NUM_BUFFERS (NB),
        .NUM_OUTPORTS(NO),
        .NUM_VCS     (NV)
    ) bus ();

    sa_request_arbiter #(
        .NUM_BUFFERS (NB),
        .NUM_OUTPORTS(NO),
        .NUM_VCS     (NV)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .bus       (bus.slave),
        .deny_count(deny_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    task automatic drive_idle();
        bus.req_valid    = '0;
        bus.req_outport  = '0;
        bus.req_vc       = '0;
        bus.switch_valid = 1'b0;
        bus.sa_enable    = '0;
    endtask

    // Short asynchronous reset pulse between clock edges.
    task automatic do_reset();
        n_rst = 1'b0;
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0;
        drive_idle();

        // ---------------- reset state ----------------
        tick();
        tick();
        settle();
        check("rst_allocate", 32'(bus.allocate), 32'd0);
        check("rst_grant",    32'(bus.req_grant), 32'd0);
        check("rst_deny",     32'(deny_count), 32'd0);
        check("rst_rr_ptr",   32'(dut.rr_ptr), 32'd0);
        n_rst = 1'b1;

        // ---------------- single request: buffer 2 -> outport 3 / VC 1 ----------------
        bus.req_valid      = 5'b00100;
        bus.req_outport[2] = 3'd3;
        bus.req_vc[2]      = 1'b1;
        bus.switch_valid   = 1'b1;
        settle();
        check("single_c0_allocate", 32'(bus.allocate), 32'd0);
        tick();
        settle();
        check("single_allocate",  32'(bus.allocate), 32'd1);
        check("single_requestor", 32'(bus.requestor), 32'd2);
        check("single_requested", 32'(bus.requested), 32'd3);
        check("single_vc",        32'(bus.requested_vc), 32'd1);
        check("single_grant",     32'(bus.req_grant), 32'b00100);
        check("single_rr_ptr",    32'(dut.rr_ptr), 32'd3);
        bus.req_valid = '0;
        tick();
        settle();
        check("single_grant_off", 32'(bus.req_grant), 32'd0);
        check("single_alloc_off", 32'(bus.allocate), 32'd0);

        // ---------------- fairness: buffers 0, 1, 4 on distinct outports ----------------
        drive_idle();
        do_reset();
        bus.req_valid      = 5'b10011;
        bus.req_outport[0] = 3'd0;
        bus.req_outport[1] = 3'd1;
        bus.req_outport[4] = 3'd4;
        bus.switch_valid   = 1'b1;
        tick(); settle();
        check("fair_grant0", 32'(bus.req_grant), 32'b00001);
        tick(); settle();
        check("fair_grant1", 32'(bus.req_grant), 32'b00010);
        tick(); settle();
        check("fair_grant4", 32'(bus.req_grant), 32'b10000);
        tick(); settle();
        check("fair_grant0_again", 32'(bus.req_grant), 32'b00001);
        bus.req_valid = '0;
        tick(); settle();
        check("fair_drain", 32'(bus.allocate), 32'd0);

        // ---------------- conflict: buffers 0 and 1 both to outport 2 / VC 0 ----------------
        drive_idle();
        do_reset();
        bus.req_valid      = 5'b00011;
        bus.req_outport[0] = 3'd2;
        bus.req_outport[1] = 3'd2;
        bus.switch_valid   = 1'b1;
        tick(); settle();
        check("conf_requestor", 32'(bus.requestor), 32'd0);
        check("conf_grant0",    32'(bus.req_grant), 32'b00001);
        // Allocator now holds outport 2 / VC 0; buffer 0 is served.
        bus.sa_enable[2][0] = 1'b1;
        bus.req_valid       = 5'b00010;
        tick(); settle();
        check("conf_masked_a", 32'(bus.allocate), 32'd0);
        tick(); settle();
        check("conf_masked_b", 32'(bus.allocate), 32'd0);
        check("conf_masked_grant", 32'(bus.req_grant), 32'd0);
        bus.sa_enable[2][0] = 1'b0;
        tick(); settle();
        check("conf_requestor1", 32'(bus.requestor), 32'd1);
        check("conf_grant1",     32'(bus.req_grant), 32'b00010);
        bus.req_valid = '0;
        tick();

        // ---------------- deny: switch_valid held low ----------------
        drive_idle();
        bus.req_valid = 5'b00001;
        for (int i = 0; i < 6; i++) begin
            tick(); settle();
            check("deny_grant",    32'(bus.req_grant), 32'd0);
            check("deny_allocate", 32'(bus.allocate), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("deny_count3", 32'(deny_count), 32'd3);

        // ---------------- withdraw: request dropped while staged ----------------
        tick(); settle();
        check("wd_allocate_on", 32'(bus.allocate), 32'd1);
        bus.req_valid = '0;
        #1;
        check("wd_allocate_off", 32'(bus.allocate), 32'd0);
        tick(); settle();
        check("wd_deny_same", 32'(deny_count), 32'd3);
        check("wd_stage_dropped", 32'(dut.stage_valid), 32'd0);

        // ---------------- wrap-around: rr_ptr = 4, requests from 1 and 4 ----------------
        bus.req_valid      = 5'b01000;
        bus.req_outport[3] = 3'd3;
        bus.switch_valid   = 1'b1;
        tick(); settle();
        check("wrap_setup_grant3", 32'(bus.req_grant), 32'b01000);
        bus.req_valid = '0;
        tick(); settle();
        check("wrap_ptr4", 32'(dut.rr_ptr), 32'd4);
        bus.req_valid      = 5'b10010;
        bus.req_outport[1] = 3'd1;
        bus.req_outport[4] = 3'd4;
        tick(); settle();
        check("wrap_grant4", 32'(bus.req_grant), 32'b10000);
        bus.req_valid = 5'b00010;
        tick(); settle();
        check("wrap_grant1", 32'(bus.req_grant), 32'b00010);
        check("wrap_ptr2",   32'(dut.rr_ptr), 32'd2);
        bus.req_valid = '0;
        tick();

        // ---------------- reset mid-operation ----------------
        drive_idle();
        bus.req_valid = 5'b00001;
        tick(); settle();
        check("mid_allocate_on", 32'(bus.allocate), 32'd1);
        #1;
        n_rst = 1'b0;
        #1;
        check("mid_allocate_off", 32'(bus.allocate), 32'd0);
        check("mid_grant",        32'(bus.req_grant), 32'd0);
        check("mid_stage_valid",  32'(dut.stage_valid), 32'd0);
        check("mid_stage_req",    32'(dut.stage_req), 32'd0);
        check("mid_rr_ptr",       32'(dut.rr_ptr), 32'd0);
        check("mid_deny",         32'(deny_count), 32'd0);
        bus.switch_valid = 1'b1;
        tick(); settle();
        check("mid_in_reset_grant", 32'(bus.req_grant), 32'd0);
        bus.req_valid = '0;
        n_rst = 1'b1;
        tick(); settle();
        check("mid_after_alloc", 32'(bus.allocate), 32'd0);
        check("mid_after_grant", 32'(bus.req_grant), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sa_request_arbiter.md
SA_REQUEST_ARBITER -- requirements
Module: sa_request_arbiter

Interface
REQ-001 SHALL have parameter NUM_BUFFERS, default 5, meaning the number of input buffers competing for allocation.
REQ-002 SHALL have parameter NUM_OUTPORTS, default 5, meaning the number of switch outports.
REQ-003 SHALL have parameter NUM_VCS, default 2, meaning the number of virtual channels per outport.
REQ-004 SHALL define widths as BUF_W, OP_W and VC_W, each equal to clog2(N) plus 1 when N == 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port n_rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 SHALL have port req_valid, input, [NUM_BUFFERS]: buffer i holds a head flit needing allocation.
REQ-008 SHALL have port req_outport, input, [NUM_BUFFERS][OP_W]: the routed outport per buffer.
REQ-009 SHALL have port req_vc, input, [NUM_BUFFERS][VC_W]: the requested VC per buffer.
REQ-010 SHALL have port req_grant, output, [NUM_BUFFERS]: one-hot grant pulse to the buffer.
REQ-011 SHALL have port allocate, output, 1 bit: request to the switch allocator.
REQ-012 SHALL have port requestor, output, BUF_W: the buffer index.
REQ-013 SHALL have port requested, output, OP_W: the outport.
REQ-014 SHALL have port requested_vc, output, VC_W: the VC.
REQ-015 SHALL have port switch_valid, input, 1 bit: same-cycle acceptance from the allocator.
REQ-016 SHALL have port sa_enable, input, [NUM_OUTPORTS][NUM_VCS]: the allocator's current allocation map.
REQ-017 SHALL have port deny_count, output, 16 bits: saturating count of denied requests.

Function
REQ-018 SHALL hold one staged request in registers: stage_valid, stage_req, stage_op and stage_vc.
REQ-019 SHALL drive allocate = stage_valid && req_valid[stage_req], with requestor, requested and requested_vc driven directly from the stage registers.
REQ-020 SHALL drive req_grant[i] = allocate && switch_valid && (stage_req == i), combinationally, one cycle wide.
REQ-021 SHALL treat the stage as resolved in any cycle where stage_valid is set: grant if allocate && switch_valid, otherwise deny or withdraw.
REQ-022 SHALL treat buffer i as a candidate when req_valid[i] is set, sa_enable[req_outport[i]][req_vc[i]] is 0, and, if stage_valid, i != stage_req and (req_outport[i], req_vc[i]) != (stage_op, stage_vc).
REQ-023 SHALL, on each edge where the stage is empty or resolved, load the round-robin winner among candidates starting at rr_ptr; with no candidate, stage_valid <= 0.
REQ-024 SHALL, on each load of winner w, set rr_ptr <= w+1, wrapping from NUM_BUFFERS-1 to 0; rr_ptr is unchanged when nothing is loaded.
REQ-025 SHALL have latency as follows: a candidate at cycle 0 with the stage empty gives allocate in cycle 1; grant and switch_valid fall in the same cycle.
REQ-026 SHALL sustain a throughput of one grant per cycle when two or more independent candidates exist.
REQ-027 SHALL handle a deny (allocate=1, switch_valid=0) as follows: deny_count increments, saturating at 0xFFFF; the buffer gets no grant and re-competes after rr_ptr advances.
REQ-028 SHALL handle a withdraw (stage_valid=1, req_valid[stage_req]=0) as follows: allocate stays low, the stage is dropped, and deny_count is unchanged.
REQ-029 SHALL ensure that a request whose outport/VC is already in sa_enable is never staged.

Reset
REQ-030 SHALL, on n_rst low, asynchronously clear stage_valid, stage_req, stage_op, stage_vc, rr_ptr and deny_count to 0.
REQ-031 SHALL therefore drive allocate=0 and req_grant=0 during reset; the first allocate is possible in the second cycle after deassertion.
REQ-032 SHALL discard, with no grant, any request that was staged when reset asserts mid-operation.

Structure
REQ-033 SHALL take the minimum-1 clog2 width helper from switch_pkg, shared with the allocator's select sizing.
REQ-034 SHALL instantiate one sub-module, rr_arbiter (parameter NUM_REQ; inputs req vector and ptr; outputs winner index and found), as a pure combinational rotate-priority encoder.
REQ-035 SHALL keep the stage registers, rr_ptr and deny_count in sa_request_arbiter.

Verification
REQ-036 SHALL cover single request: buffer 2 requests outport 3 / VC 1 with switch_valid tied to 1 -> allocate in cycle 1 with requestor=2, req_grant=5'b00100 for one cycle, and rr_ptr=3.
REQ-037 SHALL cover fairness: buffers 0, 1 and 4 hold requests to distinct outports with all grants accepted -> grant order 0,1,4,0 with no bubbles.
REQ-038 SHALL cover conflict: buffers 0 and 1 both request outport 2 / VC 0 -> only buffer 0 is staged; buffer 1 is masked once sa_enable[2][0]=1 and is granted after the enable clears.
REQ-039 SHALL cover deny: switch_valid held at 0 for 3 allocate cycles -> deny_count=3 and no req_grant.
REQ-040 SHALL cover wrap-around: rr_ptr=4 with requests from buffers 1 and 4 -> buffer 4 is granted first, then buffer 1, and rr_ptr=2.
REQ-041 SHALL cover reset mid-operation: n_rst pulsed low while allocate=1 -> allocate drops immediately, all state is 0, and no grant is issued.
